shift_serializer: RTL and testbench

SHIFT_SERIALIZER -- requirements
Module: shift_serializer

---
 rtl/shift_pkg.sv | 6 +
 rtl/bit_counter.sv | 20 ++
 rtl/shift_serializer.sv | 67 ++++++
 tb/tb_shift_serializer.sv | 126 ++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// shift_pkg: shared state encoding and default word width for the serializer
package shift_pkg;
    localparam logic IDLE          = 1'b0;
    localparam logic SHIFT         = 1'b1;
    localparam int   DEFAULT_WIDTH = 8;
endpackage

// File: rtl/bit_counter.sv
// bit_counter: modulo-MODULUS bit position counter with terminal-count decode
module bit_counter #(
    parameter int MODULUS = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tc
);
    localparam int CW = $clog2(MODULUS);
    logic [CW-1:0] count;
    assign tc = count == CW'(MODULUS - 1);
    // count bit positions, wrapping to 0 after the last bit of a word
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) count <= '0;
        else if (clear) count <= '0;
        else if (enable) count <= tc ? '0 : count + CW'(1);
    end
endmodule

// File: rtl/shift_serializer.sv
// shift_serializer: parallel-to-serial converter with a one-word holding buffer
module shift_serializer
    import shift_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             ser_last,
    output logic             busy
);
    logic             state, state_nx;
    logic [WIDTH-1:0] sreg, hbuf;
    logic             buf_full, accept, tc, last;
    logic             load_direct, load_buf, store_buf;
    assign in_ready    = ~buf_full;
    assign accept      = in_valid & in_ready;
    assign last        = (state == SHIFT) & tc;
    assign load_direct = accept & ((state == IDLE) | last);
    assign load_buf    = last & buf_full;
    assign store_buf   = accept & (state == SHIFT) & ~tc;
    bit_counter #(.MODULUS(WIDTH)) u_cnt (
        .clk    (clk),
        .reset  (reset),
        .clear  (accept & (state == IDLE)),
        .enable (state == SHIFT),
        .tc     (tc)
    );
    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else state <= state_nx;
    end
    // leave SHIFT only when the last bit goes out with nothing queued behind it
    always_comb begin
        state_nx = (state == IDLE) ? (accept ? SHIFT : IDLE)
                 : ((last & ~buf_full & ~accept) ? IDLE : SHIFT);
    end
    // shift register and holding buffer; reloads on the last-bit edge avoid bubbles
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sreg     <= '0;
            hbuf     <= '0;
            buf_full <= 1'b0;
        end else begin
            sreg     <= load_direct ? in_data
                      : load_buf ? hbuf
                      : (state == SHIFT) ? (MSB_FIRST ? sreg << 1 : sreg >> 1)
                      : sreg;
            hbuf     <= store_buf ? in_data : hbuf;
            buf_full <= store_buf ? 1'b1 : load_buf ? 1'b0 : buf_full;
        end
    end
    // serial outputs are forced low outside SHIFT
    always_comb begin
        ser_valid = state == SHIFT;
        ser_last  = last;
        ser_out   = (state == SHIFT) & (MSB_FIRST ? sreg[WIDTH-1] : sreg[0]);
        busy      = (state == SHIFT) | buf_full;
    end
endmodule

// File: tb/tb_shift_serializer.sv
// tb_shift_serializer: randomized and directed checks against a bit-queue reference model
module tb_shift_serializer;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_ready, ser_out, ser_valid, ser_last, busy;
    logic [3:0] in_data_b = '0;
    logic       in_valid_b = 1'b0;
    logic       in_ready_b, ser_out_b, ser_valid_b, ser_last_b, busy_b;
    int         checks = 0;
    int         errors = 0;
    bit         cur[$];
    logic [7:0] held[$];

    always #5 clk = ~clk;

    shift_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_a (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .ser_out(ser_out), .ser_valid(ser_valid),
        .ser_last(ser_last), .busy(busy)
    );

    shift_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_b (
        .clk(clk), .reset(reset), .in_data(in_data_b), .in_valid(in_valid_b),
        .in_ready(in_ready_b), .ser_out(ser_out_b), .ser_valid(ser_valid_b),
        .ser_last(ser_last_b), .busy(busy_b)
    );

    task automatic chk(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic load(input logic [7:0] w);
        for (int i = 0; i < 8; i++) cur.push_back(w[7-i]);
    endtask

    task automatic check_a(input string tag);
        chk({tag, ".ser_valid"}, ser_valid, cur.size() > 0);
        chk({tag, ".ser_out"}, ser_out, cur.size() > 0 ? cur[0] : 1'b0);
        chk({tag, ".ser_last"}, ser_last, cur.size() == 1);
        chk({tag, ".in_ready"}, in_ready, held.size() == 0);
        chk({tag, ".busy"}, busy, cur.size() > 0 || held.size() > 0);
    endtask

    task automatic check_b_idle(input string tag);
        chk({tag, ".b_ser_out"}, ser_out_b, 1'b0);
        chk({tag, ".b_ser_valid"}, ser_valid_b, 1'b0);
        chk({tag, ".b_ser_last"}, ser_last_b, 1'b0);
        chk({tag, ".b_busy"}, busy_b, 1'b0);
        chk({tag, ".b_in_ready"}, in_ready_b, 1'b1);
    endtask

    task automatic cycle(input string tag, input logic v, input logic [7:0] d);
        logic acc;
        in_valid = v;
        in_data  = d;
        acc = v && held.size() == 0;
        @(posedge clk);
        if (cur.size() > 0) void'(cur.pop_front());
        if (cur.size() == 0 && held.size() > 0) load(held.pop_front());
        else if (cur.size() == 0 && acc) begin
            load(d);
            acc = 1'b0;
        end
        if (acc) held.push_back(d);
        #1;
        check_a(tag);
    endtask

    initial begin
        logic [3:0] wb;
        #12;
        check_a("in_reset");
        check_b_idle("in_reset");
        reset = 1'b1;

        cycle("w_b2", 1'b1, 8'b10110010);
        for (int i = 0; i < 9; i++) cycle("w_b2", 1'b0, 8'($urandom));

        cycle("b2b_a5", 1'b1, 8'hA5);
        cycle("b2b_3c", 1'b1, 8'h3C);
        for (int g = 0; g < 20 && held.size() > 0; g++) cycle("hold_ignore", 1'b1, 8'($urandom));
        for (int i = 0; i < 10; i++) cycle("b2b_drain", 1'b0, 8'h00);

        cycle("zero_word", 1'b1, 8'h00);
        for (int g = 0; g < 20 && cur.size() > 1; g++) cycle("zero_word", 1'b0, 8'hFF);
        cycle("ones_on_last", 1'b1, 8'hFF);
        for (int i = 0; i < 10; i++) cycle("ones_drain", 1'b0, 8'h00);

        wb = 4'b0110;
        in_valid_b = 1'b1;
        in_data_b  = wb;
        cycle("lsb_acc", 1'b0, 8'h00);
        in_valid_b = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("lsb.ser_valid", ser_valid_b, 1'b1);
            chk("lsb.ser_out", ser_out_b, wb[i]);
            chk("lsb.ser_last", ser_last_b, i == 3);
            cycle("lsb_run", 1'b0, 8'h00);
        end
        check_b_idle("lsb_done");

        cycle("abort_c3", 1'b1, 8'hC3);
        cycle("abort_81", 1'b1, 8'h81);
        cycle("abort_bit3", 1'b0, 8'h00);
        #2 reset = 1'b0;
        #1;
        cur.delete();
        held.delete();
        check_a("abort_rst");
        check_b_idle("abort_rst");
        #3 reset = 1'b1;
        for (int i = 0; i < 12; i++) cycle("after_abort", 1'b0, 8'($urandom));

        for (int i = 0; i < 400; i++) cycle("rnd", 1'($urandom_range(0, 1)), 8'($urandom));
        for (int i = 0; i < 20; i++) cycle("rnd_drain", 1'b0, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
